// File: rtl/sa_pkg.sv
// Shared types, default geometry and helpers for the systolic-array scheduler.
package sa_pkg;

  localparam int unsigned ROWS_D     = 9;
  localparam int unsigned COLS_D     = 3;
  localparam int unsigned LAT_D      = ROWS_D;
  localparam int unsigned LOAD_CYC_D = 2 * ROWS_D;
  localparam int unsigned NV_W_D     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } sa_state_e;

  // Last stream cycle index: final vector enters the last row, crosses the
  // remaining columns, then drains through LAT rows.
  function automatic int unsigned stream_term(input int unsigned n,
                                              input int unsigned cols,
                                              input int unsigned lat);
    return n - 1 + cols - 1 + lat;
  endfunction

endpackage

// File: rtl/sa_window_mask.sv
// Sliding-window decoder: bit i is set while i+OFFSET <= c < i+OFFSET+n.
module sa_window_mask #(
  parameter int unsigned W      = 1,
  parameter int unsigned OFFSET = 0,
  parameter int unsigned CW     = 24
) (
  input  logic [CW-1:0] c,
  input  logic [CW-1:0] n,
  output logic [W-1:0]  mask_c
);

  // One unsigned window compare per lane; the caller guarantees no wrap.
  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      mask_c[i] = (c >= CW'(i + OFFSET)) && (c < (CW'(i + OFFSET) + n));
    end
  end

endmodule

// File: rtl/sa_sched.sv
// Sequencer for the weight-stationary pe_grid: weight load, skewed
// activation streaming, per-column output-valid flags and a done pulse.
module sa_sched
  import sa_pkg::*;
#(
  parameter int unsigned ROWS     = ROWS_D,
  parameter int unsigned COLS     = COLS_D,
  parameter int unsigned LAT      = LAT_D,
  parameter int unsigned LOAD_CYC = LOAD_CYC_D,
  parameter int unsigned NV_W     = NV_W_D
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [NV_W-1:0]          i_num_vec,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_grid_sel,
  output logic                     o_north_zero,
  output logic                     o_w_rd_en,
  output logic [$clog2(ROWS)-1:0]  o_w_rd_addr,
  output logic [ROWS-1:0]          o_row_en,
  output logic [NV_W+8-1:0]        o_stream_cnt,
  output logic [COLS-1:0]          o_col_valid
);

  localparam int unsigned CW = NV_W + 8;
  localparam int unsigned AW = $clog2(ROWS);
  localparam int unsigned KW = $clog2(LOAD_CYC + 1);

  sa_state_e     state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] term_c;
  logic [ROWS-1:0] row_mask_c;
  logic [COLS-1:0] col_mask_c;

  assign term_c = CW'(stream_term(32'(n_q), COLS, LAT));

  // State, counters and latched vector count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      n_q     <= n_d;
    end
  end

  // Next state and counter updates; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        k_d = '0;
        c_d = '0;
        if (i_start) begin
          n_d     = CW'(i_num_vec);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (k_q == KW'(LOAD_CYC - 1)) begin
          k_d     = '0;
          state_d = (n_q != '0) ? STREAM : DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      STREAM: begin
        if (c_q == term_c) begin
          state_d = DONE;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      DONE: begin
        c_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grid controls decoded from registered state and the load counter.
  always_comb begin
    o_busy       = (state_q != IDLE);
    o_done       = (state_q == DONE);
    o_grid_sel   = (state_q == LOAD);
    o_north_zero = 1'b1;
    o_w_rd_en    = 1'b0;
    o_w_rd_addr  = '0;
    if ((state_q == LOAD) && (k_q < KW'(ROWS))) begin
      o_w_rd_en    = 1'b1;
      o_north_zero = 1'b0;
      o_w_rd_addr  = AW'(ROWS - 1) - AW'(k_q);
    end
  end

  assign o_stream_cnt = c_q;

  sa_window_mask #(.W(ROWS), .OFFSET(0), .CW(CW)) u_row_mask (
    .c      (c_q),
    .n      (n_q),
    .mask_c (row_mask_c)
  );

  sa_window_mask #(.W(COLS), .OFFSET(LAT), .CW(CW)) u_col_mask (
    .c      (c_q),
    .n      (n_q),
    .mask_c (col_mask_c)
  );

  // Window flags only mean something while streaming.
  always_comb begin
    o_row_en    = '0;
    o_col_valid = '0;
    if (state_q == STREAM) begin
      o_row_en    = row_mask_c;
      o_col_valid = col_mask_c;
    end
  end

endmodule

// File: tb/tb_sa_sched.sv
// Self-checking bench for sa_sched: table runs, corner sequences, random runs.
module tb_sa_sched;

  localparam int unsigned ROWS = 9;
  localparam int unsigned COLS = 3;
  localparam int unsigned LAT  = 9;
  localparam int unsigned LC   = 18;
  localparam int unsigned NV_W = 16;
  localparam int unsigned CW   = NV_W + 8;
  localparam int unsigned AW   = 4;
  localparam int unsigned OW   = 5 + AW + ROWS + CW + COLS;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic [NV_W-1:0] i_num_vec = '0;
  logic            o_busy, o_done, o_grid_sel, o_north_zero, o_w_rd_en;
  logic [AW-1:0]   o_w_rd_addr;
  logic [ROWS-1:0] o_row_en;
  logic [CW-1:0]   o_stream_cnt;
  logic [COLS-1:0] o_col_valid;
  logic [OW-1:0]   dut_vec;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  sa_sched #(.ROWS(ROWS), .COLS(COLS), .LAT(LAT), .LOAD_CYC(LC), .NV_W(NV_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_num_vec    (i_num_vec),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_grid_sel   (o_grid_sel),
    .o_north_zero (o_north_zero),
    .o_w_rd_en    (o_w_rd_en),
    .o_w_rd_addr  (o_w_rd_addr),
    .o_row_en     (o_row_en),
    .o_stream_cnt (o_stream_cnt),
    .o_col_valid  (o_col_valid)
  );

  assign dut_vec = {o_busy, o_done, o_grid_sel, o_north_zero, o_w_rd_en,
                    o_w_rd_addr, o_row_en, o_stream_cnt, o_col_valid};

  function automatic int unsigned busy_total(input int unsigned n);
    return LC + ((n > 0) ? (n + COLS + LAT - 1) : 0) + 1;
  endfunction

  // Expected outputs in busy cycle t (t=1 is the first cycle after the accepting edge, t=0 idle).
  function automatic logic [OW-1:0] model(input int unsigned n, input int unsigned t);
    int unsigned     total;
    int unsigned     c;
    logic            busy, done, sel, nz, rden;
    logic [AW-1:0]   addr;
    logic [ROWS-1:0] re;
    logic [CW-1:0]   cnt;
    logic [COLS-1:0] cv;
    total = busy_total(n);
    busy = 1'b0; done = 1'b0; sel = 1'b0; nz = 1'b1; rden = 1'b0;
    addr = '0; re = '0; cnt = '0; cv = '0;
    if (t >= 1 && t <= total) begin
      busy = 1'b1;
      if (t <= LC) begin
        sel = 1'b1;
        if (t - 1 < ROWS) begin
          rden = 1'b1;
          nz   = 1'b0;
          addr = AW'(ROWS - t);
        end
      end else if (t < total) begin
        c   = t - 1 - LC;
        cnt = CW'(c);
        for (int unsigned r = 0; r < ROWS; r++) re[r] = (c >= r) && (c < r + n);
        for (int unsigned j = 0; j < COLS; j++) cv[j] = (c >= j + LAT) && (c < j + LAT + n);
      end else begin
        done = 1'b1;
        cnt  = (n > 0) ? CW'(n + COLS + LAT - 2) : '0;
      end
    end
    return {busy, done, sel, nz, rden, addr, re, cnt, cv};
  endfunction

  task automatic check_vec(input string name, input logic [OW-1:0] exp);
    vectors++;
    if (dut_vec !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, dut_vec, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One run: start with n, compare every cycle to the model, optionally poke
  // start at poke_t, randomly poke start, or apply reset at rst_at.
  task automatic run(input int unsigned n, input bit rnd, input int unsigned poke_t,
                     input int unsigned rst_at,
                     output int row8, output int col2, output int col0,
                     output int busy_cnt, output int done_cnt);
    int unsigned total;
    total = busy_total(n);
    row8 = 0; col2 = 0; col0 = 0; busy_cnt = 0; done_cnt = 0;
    i_start   = 1'b1;
    i_num_vec = NV_W'(n);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int unsigned t = 1; t <= total + 1; t++) begin
      check_vec($sformatf("n%0d_t%0d", n, t), model(n, t));
      row8     += int'(o_row_en[ROWS-1]);
      col2     += int'(o_col_valid[COLS-1]);
      col0     += int'(o_col_valid[0]);
      busy_cnt += int'(o_busy);
      done_cnt += int'(o_done);
      if (t == rst_at) begin
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check_vec("rst_idle", model(n, 0));
        return;
      end
      if (t <= total) begin
        i_start = 1'b0;
        if ((t == poke_t) || (rnd && $urandom_range(0, 7) == 0)) begin
          i_start   = 1'b1;
          i_num_vec = NV_W'($urandom_range(0, 30));
        end
        @(posedge i_clk); #1;
      end
      i_start = 1'b0;
    end
  endtask

  typedef struct {
    int unsigned n;
    int          busy;
    int          row8;
    int          col2;
    int          done;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int row8, col2, col0, busy_cnt, done_cnt;
    tbl[0] = '{n: 4,  busy: 34, row8: 4,  col2: 4,  done: 1};
    tbl[1] = '{n: 0,  busy: 19, row8: 0,  col2: 0,  done: 1};
    tbl[2] = '{n: 1,  busy: 31, row8: 1,  col2: 1,  done: 1};
    tbl[3] = '{n: 2,  busy: 32, row8: 2,  col2: 2,  done: 1};
    tbl[4] = '{n: 7,  busy: 37, row8: 7,  col2: 7,  done: 1};
    tbl[5] = '{n: 12, busy: 42, row8: 12, col2: 12, done: 1};

    repeat (3) @(posedge i_clk);
    #1;
    check_vec("reset_held", model(0, 0));
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check_vec("reset_idle", model(0, 0));

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].n, 1'b0, 0, 0, row8, col2, col0, busy_cnt, done_cnt);
      check_int($sformatf("tbl%0d_busy", i), busy_cnt, tbl[i].busy);
      check_int($sformatf("tbl%0d_row8", i), row8, tbl[i].row8);
      check_int($sformatf("tbl%0d_col2", i), col2, tbl[i].col2);
      check_int($sformatf("tbl%0d_done", i), done_cnt, tbl[i].done);
    end

    // Start during STREAM (t=25 is c=6) with a different count is ignored.
    run(4, 1'b0, 25, 0, row8, col2, col0, busy_cnt, done_cnt);
    check_int("poke_busy", busy_cnt, 34);
    check_int("poke_col2", col2, 4);

    // Reset at c=5, then a clean full run.
    run(4, 1'b0, 0, LC + 6, row8, col2, col0, busy_cnt, done_cnt);
    run(4, 1'b0, 0, 0, row8, col2, col0, busy_cnt, done_cnt);
    check_int("post_rst_busy", busy_cnt, 34);
    check_int("post_rst_row8", row8, 4);

    // Back-to-back starts: second accepted in the first IDLE cycle.
    run(2, 1'b0, 0, 0, row8, col2, col0, busy_cnt, done_cnt);
    check_int("b2b_run1_col0", col0, 2);
    run(1, 1'b0, 0, 0, row8, col2, col0, busy_cnt, done_cnt);
    check_int("b2b_run2_col0", col0, 1);
    check_int("b2b_run2_busy", busy_cnt, 31);

    // Random counts with random ignored start pokes.
    for (int i = 0; i < 25; i++) begin
      int unsigned n;
      n = $urandom_range(0, 20);
      run(n, 1'b1, 0, 0, row8, col2, col0, busy_cnt, done_cnt);
      check_int($sformatf("rnd%0d_busy", i), busy_cnt, int'(busy_total(n)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
